// File: rtl/cwt_coef_fetch.sv
// -----------------------------------------------------------------------------
// cwt_coef_fetch
//
// Read-side sequencer for the CWT wavelet-coefficient ROMs. A start request
// for one scale drives the shared address into the real/imaginary ROMs (both
// with a 1-cycle registered read). The returned pairs are buffered in a small
// FIFO and streamed to the frequency-domain multiplier over valid/ready,
// tagged with the bin offset inside the scale and a last flag.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset, aborts any fetch
//   start      - request a scale fetch (only looked at while idle)
//   scale_sel  - scale index 0..NUM_SCALES-1
//   busy       - high from accepted start until the last beat is handed off
//   err        - 1-cycle pulse on a start with an out-of-range scale_sel
//   rom_addr   - registered address shared by both ROMs
//   rom_rd_re  - real ROM read data (valid one cycle after the address)
//   rom_rd_im  - imaginary ROM read data
//   out_valid  - coefficient pair available at the FIFO head
//   out_ready  - downstream accepts when high together with out_valid
//   out_re     - real coefficient, two's complement
//   out_im     - imaginary coefficient, two's complement
//   out_bin    - bin offset within the scale, 0..len-1
//   out_last   - high on the final bin of the scale
// -----------------------------------------------------------------------------
module cwt_coef_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SCALES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  scale_sel,
  output logic        busy,
  output logic        err,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_rd_re,
  input  logic [15:0] rom_rd_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic [3:0]  out_bin,
  output logic        out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [4:0] NUM_SCALES_L = 5'(NUM_SCALES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Scale table: returns {base[7:0], len[3:0]} for a scale index.
  function automatic logic [11:0] scale_entry(input logic [3:0] idx);
    logic [11:0] v;
    case (idx)
      4'd0:    v = {8'd0,   4'd9};
      4'd1:    v = {8'd9,   4'd9};
      4'd2:    v = {8'd18,  4'd11};
      4'd3:    v = {8'd29,  4'd11};
      4'd4:    v = {8'd40,  4'd9};
      4'd5:    v = {8'd49,  4'd9};
      4'd6:    v = {8'd58,  4'd9};
      4'd7:    v = {8'd67,  4'd9};
      4'd8:    v = {8'd76,  4'd9};
      4'd9:    v = {8'd85,  4'd9};
      4'd10:   v = {8'd94,  4'd8};
      4'd11:   v = {8'd102, 4'd8};
      4'd12:   v = {8'd110, 4'd8};
      4'd13:   v = {8'd118, 4'd8};
      4'd14:   v = {8'd126, 4'd8};
      default: v = {8'd0,   4'd0};
    endcase
    return v;
  endfunction

  // Circular pointer advance for a FIFO_DEPTH-entry buffer.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // Control state
  state_t          r_state;
  state_t          w_next_state;
  logic [3:0]      r_len;
  logic [3:0]      r_issue_cnt;
  logic [7:0]      r_rom_addr;
  logic            r_err;

  // Read-pipeline tags: stage 1 = address on the bus, stage 2 = ROM sampled
  logic            r_p1_vld;
  logic [3:0]      r_p1_bin;
  logic            r_p1_last;
  logic            r_p2_vld;
  logic [3:0]      r_p2_bin;
  logic            r_p2_last;

  // Output FIFO
  logic [15:0]     r_fifo_re   [FIFO_DEPTH];
  logic [15:0]     r_fifo_im   [FIFO_DEPTH];
  logic [3:0]      r_fifo_bin  [FIFO_DEPTH];
  logic            r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Combinational helpers
  logic [11:0]     w_sel_entry;
  logic [7:0]      w_sel_base;
  logic [3:0]      w_sel_len;
  logic            w_sel_ok;
  logic            w_start_ok;
  logic            w_start_bad;
  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_inflight;
  logic            w_credit_ok;
  logic            w_drain_done;
  logic            w_issue;
  logic [3:0]      w_issue_bin;
  logic            w_issue_last;

  assign w_sel_entry = scale_entry(scale_sel);
  assign w_sel_base  = w_sel_entry[11:4];
  assign w_sel_len   = w_sel_entry[3:0];
  assign w_sel_ok    = ({1'b0, scale_sel} < NUM_SCALES_L);
  assign w_start_ok  = (r_state == S_IDLE) & start & w_sel_ok;
  assign w_start_bad = (r_state == S_IDLE) & start & ~w_sel_ok;

  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_p2_vld;
  assign w_inflight = {1'b0, r_p1_vld} + {1'b0, r_p2_vld};

  // Credit rule: everything already buffered or still in the ROM pipeline must
  // fit in the FIFO, so a push can never find it full.
  assign w_credit_ok = (int'(r_count) + int'(w_inflight) - int'(w_pop)) < FIFO_DEPTH;

  // No push is possible once the pipeline is empty, so only the pop matters.
  assign w_drain_done = (w_inflight == 2'd0) &&
                        ((r_count == {CNT_W{1'b0}}) ||
                         ((r_count == {{(CNT_W-1){1'b0}}, 1'b1}) && w_pop));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Leave on the edge that issues the final address of the scale.
        if (w_issue && ((r_issue_cnt + 4'd1) == r_len)) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: whether an address is issued this cycle and its bin tag
  always_comb begin
    w_issue      = 1'b0;
    w_issue_bin  = 4'd0;
    w_issue_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue      = w_start_ok;
        w_issue_bin  = 4'd0;
        w_issue_last = (w_sel_len == 4'd1);
      end
      S_ISSUE: begin
        w_issue      = w_credit_ok;
        w_issue_bin  = r_issue_cnt;
        w_issue_last = (r_issue_cnt == (r_len - 4'd1));
      end
      S_DRAIN: begin
        w_issue      = 1'b0;
        w_issue_bin  = 4'd0;
        w_issue_last = 1'b0;
      end
      default: begin
        w_issue      = 1'b0;
        w_issue_bin  = 4'd0;
        w_issue_last = 1'b0;
      end
    endcase
  end

  // Address generator, error pulse and read-pipeline tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr  <= 8'd0;
      r_len       <= 4'd0;
      r_issue_cnt <= 4'd0;
      r_err       <= 1'b0;
      r_p1_vld    <= 1'b0;
      r_p1_bin    <= 4'd0;
      r_p1_last   <= 1'b0;
      r_p2_vld    <= 1'b0;
      r_p2_bin    <= 4'd0;
      r_p2_last   <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_issue) begin
        if (r_state == S_IDLE) begin
          r_rom_addr  <= w_sel_base;
          r_len       <= w_sel_len;
          r_issue_cnt <= 4'd1;
        end else begin
          r_rom_addr  <= r_rom_addr + 8'd1;
          r_issue_cnt <= r_issue_cnt + 4'd1;
        end
      end else begin
        // rom_addr keeps its last issued value, including after a scale ends.
        r_rom_addr  <= r_rom_addr;
        r_issue_cnt <= r_issue_cnt;
      end
      r_p1_vld  <= w_issue;
      r_p1_bin  <= w_issue_bin;
      r_p1_last <= w_issue_last;
      r_p2_vld  <= r_p1_vld;
      r_p2_bin  <= r_p1_bin;
      r_p2_last <= r_p1_last;
    end
  end

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_re[i]   <= 16'd0;
        r_fifo_im[i]   <= 16'd0;
        r_fifo_bin[i]  <= 4'd0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo_re[r_wr_ptr]   <= rom_rd_re;
        r_fifo_im[r_wr_ptr]   <= rom_rd_im;
        r_fifo_bin[r_wr_ptr]  <= r_p2_bin;
        r_fifo_last[r_wr_ptr] <= r_p2_last;
        r_wr_ptr              <= ptr_next(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;
  assign rom_addr  = r_rom_addr;
  assign out_valid = (r_count != {CNT_W{1'b0}});
  assign out_re    = r_fifo_re[r_rd_ptr];
  assign out_im    = r_fifo_im[r_rd_ptr];
  assign out_bin   = r_fifo_bin[r_rd_ptr];
  assign out_last  = r_fifo_last[r_rd_ptr];

endmodule
